// File: rtl/llr_pkg.sv
// Shared types and widths for the link-layer retry receive state machine.
package llr_pkg;

   localparam int SEQ_W      = 8;
   localparam int RETRY_W    = 5;
   localparam int TMO_W      = 13;
   localparam int ACK_THRESH = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ_PEND = 3'd1,
      WAIT_ACK = 3'd2,
      REINIT   = 3'd3
   } rrsm_state_e;

   // Retry count saturates rather than wrapping back to a small value.
   function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
      return (&v) ? v : v + RETRY_W'(1);
   endfunction

endpackage

// File: rtl/llr_rx_rrsm_if.sv
// Signal bundle between the retry state machine and the unpacker/packer/PHY.
interface llr_rx_rrsm_if;
   import llr_pkg::*;

   logic               i_flit_valid;
   logic               i_crc_ok;
   logic               i_flit_is_ctrl;
   logic               i_retry_ack_rcvd;
   logic               i_req_sent;
   logic               i_ack_sent;
   logic               i_reinit_done;
   logic [SEQ_W-1:0]   i_wrap_value;
   logic [TMO_W-1:0]   i_retry_timeout_max;
   logic [RETRY_W-1:0] i_retry_threshold;
   logic [SEQ_W-1:0]   o_eseq;
   logic               o_send_retry_req;
   logic [RETRY_W-1:0] o_num_retry;
   logic               o_discard;
   logic               o_send_ack;
   logic [SEQ_W-1:0]   o_num_ack;
   logic               o_reinit_req;
   logic [2:0]         o_rrsm;

   modport slave (
      input  i_flit_valid, i_crc_ok, i_flit_is_ctrl, i_retry_ack_rcvd, i_req_sent,
             i_ack_sent, i_reinit_done, i_wrap_value, i_retry_timeout_max, i_retry_threshold,
      output o_eseq, o_send_retry_req, o_num_retry, o_discard, o_send_ack, o_num_ack,
             o_reinit_req, o_rrsm
   );

   modport master (
      output i_flit_valid, i_crc_ok, i_flit_is_ctrl, i_retry_ack_rcvd, i_req_sent,
             i_ack_sent, i_reinit_done, i_wrap_value, i_retry_timeout_max, i_retry_threshold,
      input  o_eseq, o_send_retry_req, o_num_retry, o_discard, o_send_ack, o_num_ack,
             o_reinit_req, o_rrsm
   );

endinterface

// File: rtl/llr_timeout_cnt.sv
// RETRY.Ack wait counter: cleared outside the wait, hit when the count reaches max.
module llr_timeout_cnt
   import llr_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [TMO_W-1:0] i_max,
   output logic             o_hit
);

   logic [TMO_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_clear)
         r_cnt <= '0;
      else if (i_enable)
         r_cnt <= r_cnt + TMO_W'(1);
   end

   assign o_hit = i_enable && (r_cnt == i_max);

endmodule

// File: rtl/llr_rx_rrsm.sv
// Receive-side retry state machine: sequence tracking, RETRY.Req/Ack handshake, re-init.
// Define LLR_RX_ACK_EN to build the ACK accounting counter; otherwise ACK outputs are 0.
module llr_rx_rrsm
   import llr_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   llr_rx_rrsm_if.slave bus
);

   rrsm_state_e        r_state, w_state_next;
   logic [SEQ_W-1:0]   r_eseq, w_eseq_next;
   logic [RETRY_W-1:0] r_num_retry, w_num_retry_next;
   logic [SEQ_W-1:0]   w_wrap_last;
   logic               w_good, w_discard;
   logic               w_tmo_clr, w_tmo_en, w_tmo_hit;

   // A wrap value of 0 underflows to 255, which gives the full 256-entry space.
   assign w_wrap_last = bus.i_wrap_value - SEQ_W'(1);
   assign w_good      = (r_state == IDLE) && bus.i_flit_valid && bus.i_crc_ok && !bus.i_flit_is_ctrl;
   assign w_tmo_clr   = (r_state != WAIT_ACK);
   assign w_tmo_en    = (r_state == WAIT_ACK);

   llr_timeout_cnt u_tmo (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (w_tmo_clr),
      .i_enable (w_tmo_en),
      .i_max    (bus.i_retry_timeout_max),
      .o_hit    (w_tmo_hit)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_eseq      <= '0;
         r_num_retry <= '0;
      end else begin
         r_state     <= w_state_next;
         r_eseq      <= w_eseq_next;
         r_num_retry <= w_num_retry_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_eseq_next      = r_eseq;
      w_num_retry_next = r_num_retry;
      w_discard        = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_flit_valid && !bus.i_crc_ok) begin
               w_discard        = 1'b1;
               w_state_next     = REQ_PEND;
               w_num_retry_next = retry_inc(r_num_retry);
            end else if (w_good) begin
               w_eseq_next = (r_eseq == w_wrap_last) ? '0 : r_eseq + SEQ_W'(1);
            end
         end
         REQ_PEND: begin
            w_discard = bus.i_flit_valid;
            if (bus.i_req_sent)
               w_state_next = WAIT_ACK;
         end
         WAIT_ACK: begin
            w_discard = bus.i_flit_valid;
            // Ack takes priority over a timeout landing in the same cycle.
            if (bus.i_retry_ack_rcvd) begin
               w_state_next     = IDLE;
               w_num_retry_next = '0;
            end else if (w_tmo_hit) begin
               if (r_num_retry >= bus.i_retry_threshold) begin
                  w_state_next = REINIT;
               end else begin
                  w_state_next     = REQ_PEND;
                  w_num_retry_next = retry_inc(r_num_retry);
               end
            end
         end
         REINIT: begin
            w_discard = bus.i_flit_valid;
            if (bus.i_reinit_done) begin
               w_state_next     = IDLE;
               w_eseq_next      = '0;
               w_num_retry_next = '0;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign bus.o_eseq           = r_eseq;
   assign bus.o_num_retry      = r_num_retry;
   assign bus.o_send_retry_req = (r_state == REQ_PEND);
   assign bus.o_reinit_req     = (r_state == REINIT);
   assign bus.o_rrsm           = r_state;
   assign bus.o_discard        = w_discard && !i_rst;

`ifdef LLR_RX_ACK_EN
   logic [SEQ_W-1:0] r_num_ack;
   logic [SEQ_W:0]   w_ack_sum;
   logic [SEQ_W-1:0] w_num_ack_next;

   // One extra bit so good-flit increment and ACK decrement net out before clamping.
   always_comb begin
      w_ack_sum = {1'b0, r_num_ack} + (SEQ_W+1)'(w_good);
      if (bus.i_ack_sent)
         w_ack_sum = (w_ack_sum >= (SEQ_W+1)'(ACK_THRESH)) ? w_ack_sum - (SEQ_W+1)'(ACK_THRESH) : '0;
      w_num_ack_next = r_num_ack;
      if (r_state == IDLE)
         w_num_ack_next = w_ack_sum[SEQ_W] ? '1 : w_ack_sum[SEQ_W-1:0];
      else if (r_state == REINIT && bus.i_reinit_done)
         w_num_ack_next = '0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_num_ack <= '0;
      else
         r_num_ack <= w_num_ack_next;
   end

   assign bus.o_num_ack  = r_num_ack;
   assign bus.o_send_ack = (r_num_ack >= SEQ_W'(ACK_THRESH));
`else
   assign bus.o_num_ack  = '0;
   assign bus.o_send_ack = 1'b0;
`endif

endmodule

// File: doc/llr_rx_rrsm.md
LLR_RX_RRSM -- requirements
Module: llr_rx_rrsm

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-high.
REQ-002 i_clk  in  1  sole clock, all state on rising edge.
REQ-003 i_rst  in  1  asynchronous, active-high reset.
REQ-004 i_flit_valid  in  1  unpacker presents one received flit this cycle.
REQ-005 i_crc_ok  in  1  CRC of presented flit is good; qualified by i_flit_valid.
REQ-006 i_flit_is_ctrl  in  1  flit is a link-layer control flit; control flits do not advance the sequence.
REQ-007 i_retry_ack_rcvd  in  1  single-cycle pulse: remote sent RETRY.Ack.
REQ-008 i_req_sent  in  1  packer accepted the RETRY.Req this cycle.
REQ-009 i_ack_sent  in  1  packer transmitted an ACK this cycle.
REQ-010 i_reinit_done  in  1  physical layer reports link re-initialised.
REQ-011 i_wrap_value  in  8  sequence wrap value; 0 means 256.
REQ-012 i_retry_timeout_max  in  13  cycles to wait for RETRY.Ack.
REQ-013 i_retry_threshold  in  5  retries allowed before re-init.
REQ-014 o_eseq  out  8  expected sequence number, carried in RETRY.Req.
REQ-015 o_send_retry_req  out  1  request packer to send RETRY.Req.
REQ-016 o_num_retry  out  5  current retry count.
REQ-017 o_discard  out  1  unpacker discards the current flit.
REQ-018 o_send_ack  out  1  request packer to send ACK.
REQ-019 o_num_ack  out  8  pending unacknowledged good flits.
REQ-020 o_reinit_req  out  1  request physical-layer re-init.
REQ-021 o_rrsm  out  3  current state encoding.

Function
REQ-022 States: IDLE=0, REQ_PEND=1, WAIT_ACK=2, REINIT=3. All other encodings SHALL return to IDLE.
REQ-023 IDLE: a valid flit with good CRC that is not a control flit SHALL advance o_eseq by 1, wrapping to 0 after wrap-1, and SHALL increment o_num_ack, saturating at 255.
REQ-024 IDLE: a valid flit with bad CRC SHALL force REQ_PEND on the next cycle, increment o_num_retry, and assert o_discard combinationally in the same cycle.
REQ-025 REQ_PEND: o_send_retry_req SHALL be 1 and stay held until i_req_sent; on i_req_sent go to WAIT_ACK and clear the timeout counter.
REQ-026 REQ_PEND and WAIT_ACK: every valid flit SHALL be discarded, and o_eseq and o_num_ack SHALL be frozen.
REQ-027 WAIT_ACK: the timeout counter SHALL increment every cycle. When i_retry_ack_rcvd: go to IDLE and clear o_num_retry.
REQ-028 WAIT_ACK: when the counter equals i_retry_timeout_max, go to REINIT if o_num_retry >= i_retry_threshold; otherwise go to REQ_PEND and increment o_num_retry.
REQ-029 If i_retry_ack_rcvd and the timeout occur in the same cycle, the ack SHALL win.
REQ-030 REINIT: o_reinit_req SHALL be 1. On i_reinit_done: go to IDLE and clear o_eseq, o_num_retry and o_num_ack.
REQ-031 o_send_ack SHALL be 1 while o_num_ack >= ACK_THRESH (8).
REQ-032 On i_ack_sent, o_num_ack SHALL decrease by 8. If a good flit arrives in the same cycle, the net change SHALL be -7.
REQ-033 o_num_ack SHALL never underflow; the minimum value is 0.
REQ-034 A bad-CRC flit in IDLE coinciding with i_ack_sent SHALL apply both the ack decrement and the state change.

Reset
REQ-035 While i_rst=1: state=IDLE; o_eseq, o_num_retry, o_num_ack and the timeout counter = 0; o_send_retry_req, o_discard, o_send_ack and o_reinit_req = 0.
REQ-036 Reset asserted mid-retry SHALL abandon the retry immediately with no further request pulses.

Configuration
REQ-037 Macro LLR_RX_ACK_EN: when defined, ACK accounting follows REQ-031 to REQ-033.
REQ-038 When LLR_RX_ACK_EN is undefined, o_send_ack and o_num_ack SHALL be tied to 0, i_ack_sent SHALL be ignored, and no ACK counter SHALL be synthesised.

Structure
REQ-039 Shared package llr_pkg SHALL hold rrsm_state_e, ACK_THRESH=8, SEQ_W=8, RETRY_W=5 and TMO_W=13.
REQ-040 The timeout counter SHALL be sub-module llr_timeout_cnt, with clear, enable, max and hit ports.

Verification
REQ-041 Bench: wrap=4, 6 good protocol flits -> o_eseq sequence 1,2,3,0,1,2.
REQ-042 Bench: 8 good flits -> o_send_ack=1, o_num_ack=8; then i_ack_sent with 1 good flit in the same cycle -> o_num_ack=1 and o_send_ack=0.
REQ-043 Bench: bad CRC at eseq=5 -> o_discard=1 that cycle; next cycle REQ_PEND, o_send_retry_req=1, o_num_retry=1. Then i_req_sent, then i_retry_ack_rcvd -> IDLE, o_num_retry=0, o_eseq=5.
REQ-044 Bench: threshold=2, timeout_max=10, no ack -> two timeouts, then REINIT with o_reinit_req=1. Then i_reinit_done -> IDLE with o_eseq=0.
REQ-045 Bench: i_retry_ack_rcvd in the same cycle as the timeout hit -> IDLE, not REQ_PEND.
REQ-046 Bench: i_rst pulsed during WAIT_ACK -> all outputs 0 the same cycle, state IDLE.
